// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter with bounded lock. It shares the dual-UART register file port between two cores.
// Each granted access produces exactly one single-cycle we/re strobe, followed by one ack pulse.
module uart_bus_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic              re,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  localparam logic [7:0] LP_MAX_LOCK = 8'(MAX_LOCK);

  state_t              r_state;
  state_t              w_next;
  logic                r_last_grant;
  logic                r_wr;
  logic [7:0]          r_lock_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;

  logic                w_any_req;
  logic                w_grant_en;
  logic                w_last_req;
  logic                w_last_lock;
  logic                w_other_req;
  logic                w_lock_win;
  logic                w_winner;
  logic                w_win_lock;
  logic [7:0]          w_lock_cnt_nxt;
  logic                w_sel_wr;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  assign w_any_req  = m0_req | m1_req;
  assign w_grant_en = (r_state == S_IDLE) && w_any_req;

  // Winner selection: lock holder first (while under budget), then round-robin, then lone requester.
  always_comb begin
    w_last_req  = r_last_grant ? m1_req  : m0_req;
    w_last_lock = r_last_grant ? m1_lock : m0_lock;
    w_other_req = r_last_grant ? m0_req  : m1_req;
    w_lock_win  = w_last_req && w_last_lock && (r_lock_cnt < LP_MAX_LOCK);

    if (w_lock_win)
      w_winner = r_last_grant;
    else if (m0_req && m1_req)
      w_winner = ~r_last_grant;
    else
      w_winner = m1_req;

    w_win_lock = w_winner ? m1_lock : m0_lock;

    // The count only grows while the lock is actually holding off the other core.
    if ((w_winner != r_last_grant) || !w_win_lock)
      w_lock_cnt_nxt = '0;
    else if (w_other_req)
      w_lock_cnt_nxt = r_lock_cnt + 8'd1;
    else
      w_lock_cnt_nxt = r_lock_cnt;

    w_sel_wr    = w_winner ? m1_wr    : m0_wr;
    w_sel_addr  = w_winner ? m1_addr  : m0_addr;
    w_sel_wdata = w_winner ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_any_req ? S_ACCESS : S_IDLE;
      S_ACCESS: w_next = S_ACK;
      S_ACK:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Strobes and acks are decoded from registered state only, so the outputs drop as soon as reset is asserted.
  always_comb begin
    we     = (r_state == S_ACCESS) &&  r_wr;
    re     = (r_state == S_ACCESS) && !r_wr;
    m0_ack = (r_state == S_ACK)    && !r_last_grant;
    m1_ack = (r_state == S_ACK)    &&  r_last_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_lock_cnt   <= '0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_grant_en) begin
      r_last_grant <= w_winner;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_wr         <= w_sel_wr;
      r_addr       <= w_sel_addr;
      r_wdata      <= w_sel_wdata;
    end
  end

  // Read data is captured on the edge that ends ACCESS. The strobe is then gone, so no second read side effect occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else if ((r_state == S_ACCESS) && !r_wr) begin
      if (r_last_grant)
        r_m1_rdata <= read_data;
      else
        r_m0_rdata <= read_data;
    end
  end

  assign addr       = r_addr;
  assign write_data = r_wdata;
  assign m0_rdata   = r_m0_rdata;
  assign m1_rdata   = r_m1_rdata;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Scoreboard bench for uart_bus_arbiter. Master drivers queue the expected result of each transaction.
// A monitor records each strobe/ack pair, and each test task pops both queues and compares them.
module tb_uart_bus_arbiter;

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          m;
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          scyc;
    int          acyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_v   [2];
  logic        wr_v    [2];
  logic [5:0]  addr_v  [2];
  logic [31:0] wdata_v [2];
  logic        lock_v  [2];
  logic        m0_ack, m1_ack, we, re;
  logic [31:0] m0_rdata, m1_rdata, write_data, read_data;
  logic [5:0]  addr;
  logic [31:0] rx_val = 32'h100;

  exp_t exp0_q[$];
  exp_t exp1_q[$];
  obs_t obs_q[$];

  int n_chk = 0, n_fail = 0, n_tmo = 0;
  int cyc = 0, n_we = 0, n_re = 0, n_ack = 0, n_dual = 0;
  logic        s_wr;
  logic [5:0]  s_addr;
  logic [31:0] s_wdata;
  int          s_cyc;

  uart_bus_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_LOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req_v[0]), .m0_wr(wr_v[0]), .m0_addr(addr_v[0]), .m0_wdata(wdata_v[0]),
    .m0_lock(lock_v[0]), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(req_v[1]), .m1_wr(wr_v[1]), .m1_addr(addr_v[1]), .m1_wdata(wdata_v[1]),
    .m1_lock(lock_v[1]), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .addr(addr), .we(we), .re(re), .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  // Register file model: 0x10 is a receive FIFO that advances on every read strobe.
  assign read_data = (addr == 6'h10) ? rx_val :
                     (addr == 6'h0C) ? 32'hA5A5_0042 : ({26'd0, addr} ^ 32'h5A00_0000);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (re && addr == 6'h10) rx_val <= rx_val + 32'd1;
  end

  always @(negedge clk) begin
    if (we) n_we <= n_we + 1;
    if (re) n_re <= n_re + 1;
    if ((we && re) || (m0_ack && m1_ack)) n_dual <= n_dual + 1;
    if (we || re) begin
      s_wr <= we; s_addr <= addr; s_wdata <= write_data; s_cyc <= cyc;
    end
    if (m0_ack || m1_ack) begin
      n_ack <= n_ack + 1;
      obs_q.push_back(obs_t'{m: m1_ack, wr: s_wr, addr: s_addr, wdata: s_wdata,
                             rdata: (m1_ack ? m1_rdata : m0_rdata), scyc: s_cyc, acyc: cyc});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_master(input int m, input int n, input bit wr, input logic [5:0] a0,
                            input int astep, input logic [31:0] d0, input bit lk);
    exp_t e;
    int   t;
    for (int k = 0; k < n; k++) begin
      e.wr = wr;
      e.addr = a0 + 6'(astep * k);
      e.data = d0 + 32'(k);
      wr_v[m] = wr; addr_v[m] = e.addr; wdata_v[m] = wr ? e.data : 32'd0;
      lock_v[m] = lk; req_v[m] = 1'b1;
      if (m == 1) exp1_q.push_back(e); else exp0_q.push_back(e);
      t = 0;
      do begin @(negedge clk); t++; end while (!(m == 1 ? m1_ack : m0_ack) && t < 60);
      if (t >= 60) n_tmo++;
      @(posedge clk); #1;
    end
    req_v[m] = 1'b0;
    lock_v[m] = 1'b0;
  endtask

  task automatic test_reset;
    for (int m = 0; m < 2; m++) begin
      req_v[m] = 0; wr_v[m] = 0; addr_v[m] = 0; wdata_v[m] = 0; lock_v[m] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (we !== 1'b0 || re !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: we=%b re=%b want 0 0", we, re); end
    n_chk++; if (addr !== 6'd0 || write_data !== 32'd0) begin n_fail++; $display("FAIL reset_bus: addr=%h wdata=%h want 0 0", addr, write_data); end
    n_chk++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: %b %b want 0 0", m0_ack, m1_ack); end
    n_chk++; if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: %h %h want 0 0", m0_rdata, m1_rdata); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (n_we !== 0 || n_re !== 0 || n_ack !== 0) begin n_fail++; $display("FAIL idle_no_req: we=%0d re=%0d ack=%0d want 0", n_we, n_re, n_ack); end
  endtask

  task automatic test_first_tie;
    obs_t o;
    exp_t e;
    @(posedge clk); #1;
    fork
      run_master(0, 1, 1'b1, 6'h01, 0, 32'h0000_0A0A, 1'b0);
      run_master(1, 1, 1'b1, 6'h02, 0, 32'h0000_0B0B, 1'b0);
    join
    n_chk++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL tie_count: got %0d acks want 2", obs_q.size()); end
    for (int i = 0; i < 2 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      n_chk++; if (o.m !== 1'(i)) begin n_fail++; $display("FAIL tie_order[%0d]: got m%0d want m%0d", i, o.m, i); end
      if (o.m) e = exp1_q.pop_front(); else e = exp0_q.pop_front();
      n_chk++;
      if (o.wr !== 1'b1 || o.addr !== e.addr || o.wdata !== e.data) begin
        n_fail++; $display("FAIL tie_txn[%0d]: got addr=%h data=%h want addr=%h data=%h", i, o.addr, o.wdata, e.addr, e.data);
      end
    end
  endtask

  task automatic test_write;
    int   we0, re0;
    obs_t o;
    we0 = n_we; re0 = n_re;
    @(posedge clk); #1;
    req_v[0] = 1; wr_v[0] = 1; addr_v[0] = 6'h00; wdata_v[0] = 32'h0000_1234;
    @(negedge clk);
    n_chk++; if (we !== 1'b0 || re !== 1'b0) begin n_fail++; $display("FAIL wr_cycleN: we=%b re=%b want 0 0", we, re); end
    @(negedge clk);
    n_chk++; if (we !== 1'b1 || re !== 1'b0) begin n_fail++; $display("FAIL wr_strobe: we=%b re=%b want 1 0", we, re); end
    n_chk++; if (addr !== 6'h00 || write_data !== 32'h0000_1234) begin n_fail++; $display("FAIL wr_bus: addr=%h wdata=%h want 00 00001234", addr, write_data); end
    n_chk++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL wr_early_ack: m0_ack=%b want 0", m0_ack); end
    @(negedge clk);
    n_chk++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || we !== 1'b0) begin n_fail++; $display("FAIL wr_ack: m0=%b m1=%b we=%b want 1 0 0", m0_ack, m1_ack, we); end
    @(posedge clk); #1;
    req_v[0] = 0;
    repeat (2) @(negedge clk);
    n_chk++; if (n_we - we0 !== 1 || n_re - re0 !== 0) begin n_fail++; $display("FAIL wr_strobe_count: we=%0d re=%0d want 1 0", n_we - we0, n_re - re0); end
    n_chk++; if (obs_q.size() !== 1 || m0_ack !== 1'b0) begin n_fail++; $display("FAIL wr_single_ack: acks=%0d want 1", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_read;
    @(posedge clk); #1;
    req_v[1] = 1; wr_v[1] = 0; addr_v[1] = 6'h0C; wdata_v[1] = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    n_chk++; if (re !== 1'b1 || we !== 1'b0 || addr !== 6'h0C) begin n_fail++; $display("FAIL rd_strobe: re=%b we=%b addr=%h want 1 0 0c", re, we, addr); end
    @(negedge clk);
    n_chk++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack: m1=%b m0=%b want 1 0", m1_ack, m0_ack); end
    n_chk++; if (m1_rdata !== 32'hA5A5_0042) begin n_fail++; $display("FAIL rd_data: m1_rdata=%h want a5a50042", m1_rdata); end
    n_chk++; if (m0_rdata !== 32'd0) begin n_fail++; $display("FAIL rd_other: m0_rdata=%h want 0", m0_rdata); end
    @(posedge clk); #1;
    req_v[1] = 0;
    repeat (3) @(negedge clk);
    n_chk++; if (m1_rdata !== 32'hA5A5_0042) begin n_fail++; $display("FAIL rd_hold: m1_rdata=%h want a5a50042", m1_rdata); end
    obs_q.delete();
  endtask

  task automatic test_round_robin;
    obs_t o;
    exp_t e;
    int   prev;
    @(posedge clk); #1;
    fork
      run_master(0, 4, 1'b1, 6'h20, 1, 32'h1000_0000, 1'b0);
      run_master(1, 4, 1'b1, 6'h30, 1, 32'h2000_0000, 1'b0);
    join
    n_chk++; if (obs_q.size() !== 8 || n_tmo !== 0) begin n_fail++; $display("FAIL rr_count: got %0d acks tmo=%0d want 8 0", obs_q.size(), n_tmo); end
    prev = 0;
    for (int i = 0; obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      n_chk++; if (o.m !== 1'(i % 2)) begin n_fail++; $display("FAIL rr_order[%0d]: got m%0d want m%0d", i, o.m, i % 2); end
      if (i > 0) begin
        n_chk++; if (o.acyc - prev !== 3) begin n_fail++; $display("FAIL rr_gap[%0d]: got %0d cycles want 3", i, o.acyc - prev); end
      end
      prev = o.acyc;
      if ((o.m ? exp1_q.size() : exp0_q.size()) == 0) begin
        n_chk++; n_fail++; $display("FAIL rr_extra[%0d]: unexpected ack from m%0d", i, o.m);
        continue;
      end
      if (o.m) e = exp1_q.pop_front(); else e = exp0_q.pop_front();
      n_chk++;
      if (o.wr !== e.wr || o.addr !== e.addr || o.wdata !== e.data || o.acyc !== o.scyc + 1) begin
        n_fail++; $display("FAIL rr_txn[%0d]: got wr=%0b addr=%h data=%h lat=%0d want wr=%0b addr=%h data=%h lat=1",
                           i, o.wr, o.addr, o.wdata, o.acyc - o.scyc, e.wr, e.addr, e.data);
      end
    end
    n_chk++; if (n_dual !== 0) begin n_fail++; $display("FAIL rr_dual: got %0d overlaps want 0", n_dual); end
    n_chk++; if (m0_rdata !== 32'd0 || m1_rdata !== 32'hA5A5_0042) begin n_fail++; $display("FAIL rr_rdata_kept: %h %h want 0 a5a50042", m0_rdata, m1_rdata); end
  endtask

  task automatic test_lock;
    obs_t o;
    exp_t e;
    bit   order [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
    @(posedge clk); #1;
    fork
      run_master(0, 7, 1'b1, 6'h00, 1, 32'h4000_0000, 1'b1);
      run_master(1, 2, 1'b0, 6'h10, 0, 32'h0000_0100, 1'b0);
    join
    n_chk++; if (obs_q.size() !== 9 || n_tmo !== 0) begin n_fail++; $display("FAIL lock_count: got %0d acks tmo=%0d want 9 0", obs_q.size(), n_tmo); end
    for (int i = 0; i < 9 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      n_chk++; if (o.m !== order[i]) begin n_fail++; $display("FAIL lock_order[%0d]: got m%0d want m%0d", i, o.m, order[i]); end
      if ((o.m ? exp1_q.size() : exp0_q.size()) == 0) begin
        n_chk++; n_fail++; $display("FAIL lock_extra[%0d]: unexpected ack from m%0d", i, o.m);
        continue;
      end
      if (o.m) e = exp1_q.pop_front(); else e = exp0_q.pop_front();
      n_chk++;
      if (o.wr !== e.wr || o.addr !== e.addr || (e.wr ? o.wdata : o.rdata) !== e.data || o.acyc !== o.scyc + 1) begin
        n_fail++; $display("FAIL lock_txn[%0d]: got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                           i, o.wr, o.addr, (e.wr ? o.wdata : o.rdata), e.wr, e.addr, e.data);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    obs_t o;
    exp_t e;
    int   re0, ack0, prev;
    re0 = n_re; ack0 = n_ack;
    @(posedge clk); #1;
    run_master(0, 4, 1'b0, 6'h10, 0, 32'h0000_0102, 1'b0);
    @(negedge clk);
    n_chk++; if (n_re - re0 !== 4 || n_ack - ack0 !== 4) begin n_fail++; $display("FAIL b2b_counts: re=%0d ack=%0d want 4 4", n_re - re0, n_ack - ack0); end
    prev = 0;
    for (int i = 0; obs_q.size() > 0 && exp0_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp0_q.pop_front();
      n_chk++;
      if (o.m !== 1'b0 || o.wr !== 1'b0 || o.rdata !== e.data || o.addr !== 6'h10) begin
        n_fail++; $display("FAIL b2b_txn[%0d]: got m%0d wr=%0b addr=%h rdata=%h want m0 wr=0 addr=10 rdata=%h", i, o.m, o.wr, o.addr, o.rdata, e.data);
      end
      if (i > 0) begin
        n_chk++; if (o.acyc - prev !== 3) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d cycles want 3", i, o.acyc - prev); end
      end
      prev = o.acyc;
    end
    n_chk++; if (m0_rdata !== 32'h0000_0105) begin n_fail++; $display("FAIL b2b_hold: m0_rdata=%h want 00000105", m0_rdata); end
    obs_q.delete();
  endtask

  task automatic test_async_reset;
    obs_t o;
    exp_t e;
    int   we0, t;
    bit   ack_seen;
    we0 = n_we;
    @(posedge clk); #1;
    req_v[0] = 1; wr_v[0] = 1; addr_v[0] = 6'h3F; wdata_v[0] = 32'h0000_CAFE;
    repeat (2) @(negedge clk);
    n_chk++; if (we !== 1'b1 || addr !== 6'h3F) begin n_fail++; $display("FAIL ar_pre: we=%b addr=%h want 1 3f", we, addr); end
    #2;
    rst_n = 1'b0;
    req_v[0] = 0;
    req_v[1] = 1; wr_v[1] = 1; addr_v[1] = 6'h05; wdata_v[1] = 32'h0000_0055; lock_v[1] = 0;
    e.wr = 1; e.addr = 6'h05; e.data = 32'h0000_0055;
    exp1_q.push_back(e);
    #1;
    n_chk++; if (we !== 1'b0 || re !== 1'b0) begin n_fail++; $display("FAIL ar_strobe_drop: we=%b re=%b want 0 0", we, re); end
    n_chk++; if (addr !== 6'd0 || write_data !== 32'd0 || m1_rdata !== 32'd0) begin n_fail++; $display("FAIL ar_values: addr=%h wdata=%h m1_rdata=%h want 0", addr, write_data, m1_rdata); end
    ack_seen = 0;
    repeat (3) begin @(negedge clk); if (m0_ack || m1_ack) ack_seen = 1; end
    n_chk++; if (ack_seen !== 1'b0) begin n_fail++; $display("FAIL ar_no_ack: ack seen during reset want none"); end
    rst_n = 1'b1;
    t = 0;
    do begin @(posedge clk); t++; @(negedge clk); end while (!m1_ack && t < 3);
    n_chk++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin n_fail++; $display("FAIL ar_m1_served: m1_ack=%b after %0d cycles want 1 within 3", m1_ack, t); end
    @(posedge clk); #1;
    req_v[1] = 0;
    repeat (2) @(negedge clk);
    n_chk++; if (obs_q.size() !== 1 || n_we - we0 !== 2) begin n_fail++; $display("FAIL ar_counts: acks=%0d strobes=%0d want 1 2", obs_q.size(), n_we - we0); end
    if (obs_q.size() > 0 && exp1_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp1_q.pop_front();
      n_chk++;
      if (o.m !== 1'b1 || o.addr !== e.addr || o.wdata !== e.data) begin
        n_fail++; $display("FAIL ar_txn: got m%0d addr=%h data=%h want m1 addr=%h data=%h", o.m, o.addr, o.wdata, e.addr, e.data);
      end
    end
    n_chk++; if (n_dual !== 0 || n_tmo !== 0 || exp0_q.size() !== 0) begin n_fail++; $display("FAIL final_state: dual=%0d tmo=%0d pending=%0d want 0", n_dual, n_tmo, exp0_q.size()); end
  endtask

  initial begin
    test_reset;
    test_first_tie;
    test_write;
    test_read;
    test_round_robin;
    test_lock;
    test_back_to_back;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
